// File: rtl/kat_adc_frame_aligner.sv
// rtl/kat_adc_frame_aligner.sv - sync-locked barrel realigner for interleaved multi-channel ADC words
module kat_adc_frame_aligner #(
  parameter int N_CHAN     = 2,
  parameter int N_SAMP     = 4,
  parameter int DATA_W     = 8,
  parameter int PER_W      = 16,
  parameter int LOCK_COUNT = 3,
  parameter int OR_CNT_W   = 16
) (
  input  logic                             adc_clk,
  input  logic                             ctrl_reset,
  input  logic [N_CHAN*N_SAMP*DATA_W-1:0]  in_data,
  input  logic [N_SAMP-1:0]                in_sync,
  input  logic [N_CHAN-1:0]                in_outofrange,
  input  logic                             in_valid,
  input  logic [PER_W-1:0]                 sync_period,
  input  logic                             realign_en,
  input  logic                             or_clear,
  output logic [N_CHAN*N_SAMP*DATA_W-1:0]  out_data,
  output logic                             out_valid,
  output logic                             out_sync,
  output logic [$clog2(N_SAMP)-1:0]        offset,
  output logic                             locked,
  output logic                             lock_lost,
  output logic [N_CHAN*OR_CNT_W-1:0]       or_count
);

  localparam int OFF_W  = $clog2(N_SAMP);
  localparam int CH_W   = N_SAMP*DATA_W;
  localparam int WORD_W = N_CHAN*CH_W;
  localparam int HIT_W  = $clog2(LOCK_COUNT+1);

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

  state_t             state;
  logic [HIT_W-1:0]   hits;
  logic [PER_W-1:0]   per_cnt;
  logic               prev_msb;
  logic [WORD_W-1:0]  hist_data;
  logic               hist_valid;
  logic               hist_edge_found;
  logic [OFF_W-1:0]   hist_edge_slot;

  logic [N_SAMP-1:0]  edges;
  logic               edge_found;
  logic [OFF_W-1:0]   edge_slot;
  logic [PER_W-1:0]   cnt_now;
  logic               period_on;
  logic               mismatch;
  logic [WORD_W-1:0]  aligned;
  logic [2*CH_W-1:0]  pair;

  // Rising sync edges across the word boundary; the lowest slot wins.
  always_comb begin
    edges      = in_sync & ~{in_sync[N_SAMP-2:0], prev_msb};
    edge_found = 1'b0;
    edge_slot  = '0;
    for (int i = N_SAMP-1; i >= 0; i--) begin
      if (edges[i]) begin
        edge_found = 1'b1;
        edge_slot  = OFF_W'(i);
      end
    end
  end

  // Period bookkeeping: count value this word would carry and whether it breaks the expected cadence.
  always_comb begin
    cnt_now   = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
    period_on = (sync_period != '0);
    mismatch  = 1'b0;
    if (period_on) begin
      if (edge_found)
        mismatch = !((cnt_now == sync_period) && (edge_slot == offset));
      else
        mismatch = (cnt_now > sync_period);
    end
  end

  // Per channel, slide an N_SAMP window over {current, history} starting at the offset.
  always_comb begin
    aligned = '0;
    pair    = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      pair = {in_data[c*CH_W +: CH_W], hist_data[c*CH_W +: CH_W]};
      for (int k = 0; k < N_SAMP; k++)
        aligned[(c*N_SAMP+k)*DATA_W +: DATA_W] = pair[(int'(offset)+k)*DATA_W +: DATA_W];
    end
  end

  // Lock FSM: acquire an edge, confirm LOCK_COUNT periodic edges, drop back on any cadence error.
  always_ff @(posedge adc_clk) begin
    if (ctrl_reset) begin
      state     <= ST_SEARCH;
      hits      <= '0;
      per_cnt   <= '0;
      offset    <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else if (in_valid) begin
      per_cnt <= cnt_now;
      case (state)
        ST_SEARCH: begin
          if (edge_found) begin
            offset  <= edge_slot;
            hits    <= HIT_W'(1);
            per_cnt <= '0;
            if (!period_on || LOCK_COUNT == 1) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else begin
              state <= ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (!period_on) begin
            state  <= ST_LOCKED;
            locked <= 1'b1;
          end else if (mismatch) begin
            state <= ST_SEARCH;
            hits  <= '0;
          end else if (edge_found) begin
            per_cnt <= '0;
            hits    <= hits + 1'b1;
            if (int'(hits) + 1 >= LOCK_COUNT) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (period_on) begin
            if (mismatch) begin
              state     <= ST_SEARCH;
              hits      <= '0;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
            end else if (edge_found) begin
              per_cnt <= '0;
            end
          end
        end
        default: begin
          state  <= ST_SEARCH;
          hits   <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // History capture and registered output word in realign or pass-through mode.
  always_ff @(posedge adc_clk) begin
    if (ctrl_reset) begin
      hist_data       <= '0;
      hist_valid      <= 1'b0;
      hist_edge_found <= 1'b0;
      hist_edge_slot  <= '0;
      prev_msb        <= 1'b0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_sync        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      if (in_valid) begin
        hist_data       <= in_data;
        hist_valid      <= 1'b1;
        hist_edge_found <= edge_found;
        hist_edge_slot  <= edge_slot;
        prev_msb        <= in_sync[N_SAMP-1];
        if (realign_en) begin
          out_data  <= aligned;
          out_valid <= hist_valid;
          out_sync  <= hist_valid && hist_edge_found && (hist_edge_slot == offset);
        end else begin
          out_data  <= in_data;
          out_valid <= 1'b1;
          out_sync  <= in_sync[0];
        end
      end
    end
  end

  // Saturating per-channel overrange counters; clear wins over a same-cycle increment.
  always_ff @(posedge adc_clk) begin
    if (ctrl_reset) begin
      or_count <= '0;
    end else begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (or_clear)
          or_count[c*OR_CNT_W +: OR_CNT_W] <= '0;
        else if (in_valid && in_outofrange[c] && (or_count[c*OR_CNT_W +: OR_CNT_W] != '1))
          or_count[c*OR_CNT_W +: OR_CNT_W] <= or_count[c*OR_CNT_W +: OR_CNT_W] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kat_adc_frame_aligner.sv
// tb/tb_kat_adc_frame_aligner.sv - self-checking bench for kat_adc_frame_aligner
module tb_kat_adc_frame_aligner;
  localparam int N_CHAN = 2;
  localparam int N_SAMP = 4;
  localparam int DATA_W = 8;
  localparam int PER_W  = 16;
  localparam int LOCK   = 3;
  localparam int WORD_W = N_CHAN*N_SAMP*DATA_W;
  localparam int S_SEARCH = 0, S_VERIFY = 1, S_LOCKED = 2;

  logic adc_clk = 1'b0;
  logic ctrl_reset = 1'b1, in_valid = 1'b0, realign_en = 1'b1, or_clear = 1'b0;
  logic [WORD_W-1:0] in_data = '0;
  logic [N_SAMP-1:0] in_sync = '0;
  logic [N_CHAN-1:0] in_outofrange = '0;
  logic [PER_W-1:0]  sync_period = '0;

  logic [WORD_W-1:0] out_data, out_data_s;
  logic out_valid, out_valid_s, out_sync, out_sync_s, locked, locked_s, lock_lost, lock_lost_s;
  logic [1:0] offset, offset_s;
  logic [N_CHAN*16-1:0] or_count;
  logic [N_CHAN*4-1:0]  or_count_s;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: whole sample/sync streams plus word-index bookkeeping.
  logic [WORD_W-1:0] m_words[$];
  bit   m_sync[$];
  int   m_edge[$];
  int   m_state, m_off, m_hits, m_last;
  bit   m_lost;
  int   m_or[N_CHAN];
  int   m_or_s[N_CHAN];
  bit   e_valid, e_sync;
  logic [WORD_W-1:0] e_data;

  kat_adc_frame_aligner #(.N_CHAN(2), .N_SAMP(4), .DATA_W(8), .PER_W(16), .LOCK_COUNT(3), .OR_CNT_W(16)) dut (
    .adc_clk(adc_clk), .ctrl_reset(ctrl_reset), .in_data(in_data), .in_sync(in_sync),
    .in_outofrange(in_outofrange), .in_valid(in_valid), .sync_period(sync_period),
    .realign_en(realign_en), .or_clear(or_clear), .out_data(out_data), .out_valid(out_valid),
    .out_sync(out_sync), .offset(offset), .locked(locked), .lock_lost(lock_lost), .or_count(or_count));

  kat_adc_frame_aligner #(.N_CHAN(2), .N_SAMP(4), .DATA_W(8), .PER_W(16), .LOCK_COUNT(3), .OR_CNT_W(4)) dut_s (
    .adc_clk(adc_clk), .ctrl_reset(ctrl_reset), .in_data(in_data), .in_sync(in_sync),
    .in_outofrange(in_outofrange), .in_valid(in_valid), .sync_period(sync_period),
    .realign_en(realign_en), .or_clear(or_clear), .out_data(out_data_s), .out_valid(out_valid_s),
    .out_sync(out_sync_s), .offset(offset_s), .locked(locked_s), .lock_lost(lock_lost_s), .or_count(or_count_s));

  always #5 adc_clk = ~adc_clk;

  function automatic logic [DATA_W-1:0] samp(int c, int g);
    logic [WORD_W-1:0] wd;
    wd = m_words[g / N_SAMP];
    return wd[(c*N_SAMP + g % N_SAMP)*DATA_W +: DATA_W];
  endfunction

  function automatic logic [WORD_W-1:0] ramp_word(int w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int c = 0; c < N_CHAN; c++)
      for (int i = 0; i < N_SAMP; i++)
        r[(c*N_SAMP+i)*DATA_W +: DATA_W] = DATA_W'(w*N_SAMP + i + c*100);
    return r;
  endfunction

  task automatic model_reset();
    m_words.delete(); m_sync.delete(); m_edge.delete();
    m_state = S_SEARCH; m_off = 0; m_hits = 0; m_last = 0; m_lost = 0;
    for (int c = 0; c < N_CHAN; c++) begin m_or[c] = 0; m_or_s[c] = 0; end
    e_valid = 0; e_sync = 0; e_data = '0;
  endtask

  task automatic model_word(input logic v, input logic [WORD_W-1:0] d, input logic [N_SAMP-1:0] s,
                            input logic [N_CHAN-1:0] orf, input logic clr);
    int w, p, gap;
    bit good, bad;
    for (int c = 0; c < N_CHAN; c++) begin
      if (clr) begin m_or[c] = 0; m_or_s[c] = 0; end
      else if (v && orf[c]) begin
        if (m_or[c] < 65535) m_or[c]++;
        if (m_or_s[c] < 15) m_or_s[c]++;
      end
    end
    if (!v) begin e_valid = 0; e_sync = 0; return; end
    w = m_words.size();
    m_words.push_back(d);
    for (int i = 0; i < N_SAMP; i++) m_sync.push_back(s[i]);
    p = -1;
    for (int i = N_SAMP-1; i >= 0; i--) begin
      int g;
      g = w*N_SAMP + i;
      if (m_sync[g] && !(g > 0 && m_sync[g-1])) p = i;
    end
    if (realign_en) begin
      e_valid = (w > 0);
      e_sync  = (w > 0) && (m_edge[w-1] == m_off);
      if (w > 0)
        for (int c = 0; c < N_CHAN; c++)
          for (int k = 0; k < N_SAMP; k++)
            e_data[(c*N_SAMP+k)*DATA_W +: DATA_W] = samp(c, (w-1)*N_SAMP + m_off + k);
    end else begin
      e_valid = 1; e_sync = s[0]; e_data = d;
    end
    m_edge.push_back(p);
    if (m_state == S_SEARCH) begin
      if (p >= 0) begin
        m_off = p; m_hits = 1; m_last = w;
        m_state = (sync_period == 0 || LOCK == 1) ? S_LOCKED : S_VERIFY;
      end
    end else if (sync_period == 0) begin
      m_state = S_LOCKED;
    end else begin
      good = 0; bad = 0;
      gap = w - m_last;
      if (p >= 0) begin
        if (gap == int'(sync_period) && p == m_off) good = 1; else bad = 1;
      end else if (gap > int'(sync_period)) bad = 1;
      if (good) begin
        m_last = w;
        if (m_state == S_VERIFY) begin
          m_hits++;
          if (m_hits >= LOCK) m_state = S_LOCKED;
        end
      end
      if (bad) begin
        if (m_state == S_LOCKED) m_lost = 1;
        m_state = S_SEARCH; m_hits = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [WORD_W-1:0] d, input logic [N_SAMP-1:0] s,
                      input logic [N_CHAN-1:0] orf, input logic clr);
    in_valid = v; in_data = d; in_sync = s; in_outofrange = orf; or_clear = clr;
    model_word(v, d, s, orf, clr);
    @(posedge adc_clk); #1;
  endtask

  task automatic do_reset();
    ctrl_reset = 1; in_valid = 0; in_sync = '0; in_outofrange = '0; or_clear = 0; in_data = '0;
    @(posedge adc_clk); #1;
    ctrl_reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL rst_out_data got %0h exp 0", out_data); end
    n_checks++; if (out_sync !== 1'b0) begin n_errors++; $display("FAIL rst_out_sync got %0b exp 0", out_sync); end
    n_checks++; if (offset !== 2'd0) begin n_errors++; $display("FAIL rst_offset got %0d exp 0", offset); end
    n_checks++; if ({locked, lock_lost} !== 2'b00) begin n_errors++; $display("FAIL rst_lock got %b exp 00", {locked, lock_lost}); end
    n_checks++; if (or_count !== '0 || or_count_s !== '0) begin n_errors++; $display("FAIL rst_or_count got %0h/%0h exp 0", or_count, or_count_s); end
  endtask

  task automatic test_lock_acquire();
    logic [WORD_W-1:0] d, w16;
    do_reset();
    sync_period = 8; realign_en = 1; w16 = '0;
    for (int w = 0; w < 18; w++) begin
      d = {$urandom(), $urandom()};
      if (w == 16) w16 = d;
      step(1'b1, d, (w % 8 == 0) ? 4'b0100 : 4'b0000, '0, 1'b0);
      n_checks++; if (locked !== m_state[1]) begin n_errors++; $display("FAIL acq_locked w%0d got %0b exp %0b", w, locked, m_state == S_LOCKED); end
      n_checks++; if (offset !== 2'(m_off)) begin n_errors++; $display("FAIL acq_offset w%0d got %0d exp %0d", w, offset, m_off); end
      n_checks++; if (out_valid !== e_valid) begin n_errors++; $display("FAIL acq_out_valid w%0d got %0b exp %0b", w, out_valid, e_valid); end
      if (e_valid) begin
        n_checks++; if (out_data !== e_data) begin n_errors++; $display("FAIL acq_out_data w%0d got %0h exp %0h", w, out_data, e_data); end
        n_checks++; if (out_sync !== e_sync) begin n_errors++; $display("FAIL acq_out_sync w%0d got %0b exp %0b", w, out_sync, e_sync); end
      end
      if (w == 0) begin
        n_checks++; if (offset !== 2'd2 || locked !== 1'b0) begin n_errors++; $display("FAIL acq_first_edge got off=%0d lk=%0b exp off=2 lk=0", offset, locked); end
      end
      if (w == 15) begin
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL acq_early_lock got %0b exp 0", locked); end
      end
      if (w == 16) begin
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL acq_lock got %0b exp 1", locked); end
      end
      if (w == 17) begin
        n_checks++; if (out_sync !== 1'b1 || out_data[7:0] !== w16[23:16]) begin n_errors++; $display("FAIL acq_sync_sample got sync=%0b s0=%0h exp sync=1 s0=%0h", out_sync, out_data[7:0], w16[23:16]); end
      end
    end
  endtask

  task automatic test_lock_loss();
    logic [N_SAMP-1:0] s;
    for (int w = 18; w < 49; w++) begin
      s = (w == 23 || w == 31 || w == 39 || w == 47) ? 4'b0100 : 4'b0000;
      step(1'b1, {$urandom(), $urandom()}, s, '0, 1'b0);
      n_checks++; if (locked !== m_state[1] || lock_lost !== m_lost) begin n_errors++; $display("FAIL loss_model w%0d got lk=%0b ll=%0b exp lk=%0b ll=%0b", w, locked, lock_lost, m_state == S_LOCKED, m_lost); end
      if (e_valid) begin
        n_checks++; if (out_data !== e_data || out_sync !== e_sync) begin n_errors++; $display("FAIL loss_out w%0d got %0h/%0b exp %0h/%0b", w, out_data, out_sync, e_data, e_sync); end
      end
      if (w == 23) begin
        n_checks++; if (locked !== 1'b0 || lock_lost !== 1'b1 || offset !== 2'd2) begin n_errors++; $display("FAIL loss_early_edge got lk=%0b ll=%0b off=%0d exp lk=0 ll=1 off=2", locked, lock_lost, offset); end
      end
      if (w == 39) begin
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL loss_reuse got %0b exp 0", locked); end
      end
      if (w == 47) begin
        n_checks++; if (locked !== 1'b1 || lock_lost !== 1'b1) begin n_errors++; $display("FAIL loss_relock got lk=%0b ll=%0b exp lk=1 ll=1", locked, lock_lost); end
      end
    end
  endtask

  task automatic test_period_zero();
    logic [DATA_W-1:0] exp_s;
    do_reset();
    sync_period = 0; realign_en = 1;
    for (int w = 0; w < 8; w++) begin
      step(1'b1, ramp_word(w), (w == 0) ? 4'b1000 : ((w == 5) ? 4'b0010 : 4'b0000), '0, 1'b0);
      n_checks++; if (locked !== 1'b1 || offset !== 2'd3) begin n_errors++; $display("FAIL pz_lock w%0d got lk=%0b off=%0d exp lk=1 off=3", w, locked, offset); end
      if (w >= 1) begin
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL pz_valid w%0d got %0b exp 1", w, out_valid); end
        for (int c = 0; c < N_CHAN; c++)
          for (int k = 0; k < N_SAMP; k++) begin
            exp_s = DATA_W'((w-1)*N_SAMP + 3 + k + c*100);
            n_checks++; if (out_data[(c*N_SAMP+k)*DATA_W +: DATA_W] !== exp_s) begin n_errors++; $display("FAIL pz_sample w%0d c%0d k%0d got %0d exp %0d", w, c, k, out_data[(c*N_SAMP+k)*DATA_W +: DATA_W], exp_s); end
          end
      end
      if (w == 1) begin
        n_checks++; if (out_sync !== 1'b1) begin n_errors++; $display("FAIL pz_sync got %0b exp 1", out_sync); end
      end
    end
  endtask

  task automatic test_passthrough();
    logic v;
    logic [WORD_W-1:0] d;
    logic [N_SAMP-1:0] s;
    realign_en = 0;
    for (int i = 0; i < 24; i++) begin
      v = (i < 3) ? (i != 1) : 1'($urandom_range(0, 1));
      d = {$urandom(), $urandom()};
      s = 4'($urandom_range(0, 15));
      step(v, d, s, '0, 1'b0);
      n_checks++; if (out_valid !== v) begin n_errors++; $display("FAIL pt_valid i%0d got %0b exp %0b", i, out_valid, v); end
      if (v) begin
        n_checks++; if (out_data !== d || out_sync !== s[0]) begin n_errors++; $display("FAIL pt_data i%0d got %0h/%0b exp %0h/%0b", i, out_data, out_sync, d, s[0]); end
      end
    end
  endtask

  task automatic test_overrange();
    step(1'b1, '0, '0, 2'b00, 1'b1);
    n_checks++; if (or_count !== '0) begin n_errors++; $display("FAIL or_clear0 got %0h exp 0", or_count); end
    for (int i = 0; i < 10; i++) step(1'(i % 2 == 0), '0, '0, 2'b10, 1'b0);
    n_checks++; if (or_count[31:16] !== 16'd5 || or_count[15:0] !== 16'd0) begin n_errors++; $display("FAIL or_five got %0d/%0d exp 5/0", or_count[31:16], or_count[15:0]); end
    step(1'b1, '0, '0, 2'b11, 1'b1);
    n_checks++; if (or_count !== '0 || or_count_s !== '0) begin n_errors++; $display("FAIL or_clear_prio got %0h/%0h exp 0", or_count, or_count_s); end
    for (int i = 0; i < 20; i++) step(1'b1, '0, '0, 2'b01, 1'b0);
    n_checks++; if (or_count[15:0] !== 16'd20) begin n_errors++; $display("FAIL or_twenty got %0d exp 20", or_count[15:0]); end
    n_checks++; if (or_count_s !== 8'h0F) begin n_errors++; $display("FAIL or_saturate got %0h exp 0f", or_count_s); end
  endtask

  task automatic test_reset_mid_verify();
    do_reset();
    sync_period = 8; realign_en = 1;
    for (int w = 0; w < 4; w++) step(1'b1, {$urandom(), $urandom()}, (w == 0) ? 4'b0010 : 4'b0000, 2'b01, 1'b0);
    ctrl_reset = 1; in_valid = 1; in_sync = 4'b0100; in_outofrange = 2'b11;
    @(posedge adc_clk); #1;
    ctrl_reset = 0;
    model_reset();
    n_checks++; if ({out_valid, out_sync, locked, lock_lost} !== 4'b0 || offset !== 2'd0) begin n_errors++; $display("FAIL mid_rst_ctl got %b off=%0d exp 0000 off=0", {out_valid, out_sync, locked, lock_lost}, offset); end
    n_checks++; if (out_data !== '0 || or_count !== '0) begin n_errors++; $display("FAIL mid_rst_data got %0h/%0h exp 0", out_data, or_count); end
    step(1'b1, {$urandom(), $urandom()}, 4'b0100, '0, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || locked !== 1'b0 || offset !== 2'd2) begin n_errors++; $display("FAIL mid_rst_first got v=%0b lk=%0b off=%0d exp v=0 lk=0 off=2", out_valid, locked, offset); end
  endtask

  task automatic test_random();
    logic v, clr;
    logic [N_SAMP-1:0] s;
    logic [N_CHAN-1:0] orf;
    int wv;
    do_reset();
    sync_period = 4; realign_en = 1; wv = 0;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 4) != 0);
      if (v) begin
        s = (wv % 4 == 0) ? 4'b0010 : 4'b0000;
        if ($urandom_range(0, 9) == 0) s = 4'($urandom_range(0, 15));
        wv++;
      end else s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) realign_en = ~realign_en;
      orf = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 19) == 0);
      step(v, {$urandom(), $urandom()}, s, orf, clr);
      n_checks++; if (out_valid !== e_valid) begin n_errors++; $display("FAIL rnd_valid i%0d got %0b exp %0b", i, out_valid, e_valid); end
      n_checks++; if (locked !== m_state[1] || lock_lost !== m_lost || offset !== 2'(m_off)) begin n_errors++; $display("FAIL rnd_lock i%0d got lk=%0b ll=%0b off=%0d exp lk=%0b ll=%0b off=%0d", i, locked, lock_lost, offset, m_state == S_LOCKED, m_lost, m_off); end
      n_checks++; if (or_count !== {16'(m_or[1]), 16'(m_or[0])} || or_count_s !== {4'(m_or_s[1]), 4'(m_or_s[0])}) begin n_errors++; $display("FAIL rnd_or i%0d got %0h/%0h exp %0d,%0d/%0d,%0d", i, or_count, or_count_s, m_or[1], m_or[0], m_or_s[1], m_or_s[0]); end
      if (e_valid) begin
        n_checks++; if (out_data !== e_data || out_sync !== e_sync) begin n_errors++; $display("FAIL rnd_out i%0d got %0h/%0b exp %0h/%0b", i, out_data, out_sync, e_data, e_sync); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_acquire();
    test_lock_loss();
    test_period_zero();
    test_passthrough();
    test_overrange();
    test_reset_mid_verify();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/kat_adc_frame_aligner.md
Name: kat_adc_frame_aligner

Overview:
- Parametrised post-capture stage for multi-channel interleaved ADC streams.
- Sits after the ADC clock-domain FIFO. Takes N_CHAN channels x N_SAMP samples per word plus per-sample sync bits and per-channel overrange flags.
- Locks to a periodic sync edge and barrel-realigns samples so that output sample 0 is the sync sample.
- Reports lock status and keeps saturating per-channel overrange counters.

Parameters:
- N_CHAN, 2, number of channels.
- N_SAMP, 4, samples per channel per word (power of 2, >=2).
- DATA_W, 8, bits per sample.
- PER_W, 16, width of the sync-period counter.
- LOCK_COUNT, 3, consecutive correct sync edges required for lock (>=1).
- OR_CNT_W, 16, width of each overrange counter.

Ports:
- adc_clk, in, 1: single clock for all logic.
- ctrl_reset, in, 1: synchronous, active-high reset.
- in_data, in, N_CHAN*N_SAMP*DATA_W: sample s of channel c at [(c*N_SAMP+s)*DATA_W +: DATA_W]; sample 0 is oldest.
- in_sync, in, N_SAMP: sync bit per sample slot.
- in_outofrange, in, N_CHAN: overrange flag per channel for this word.
- in_valid, in, 1: word qualifier.
- sync_period, in, PER_W: expected valid words between sync edges; 0 disables periodicity checking.
- realign_en, in, 1: 1 = apply offset; 0 = pass-through.
- or_clear, in, 1: clears all overrange counters.
- out_data, out, N_CHAN*N_SAMP*DATA_W: realigned word, same packing as in_data.
- out_valid, out, 1: qualifies out_data and out_sync.
- out_sync, out, 1: output sample 0 is a sync-edge sample.
- offset, out, log2(N_SAMP): current alignment offset.
- locked, out, 1: in LOCKED state.
- lock_lost, out, 1: sticky; set on any LOCKED->SEARCH transition; cleared only by reset.
- or_count, out, N_CHAN*OR_CNT_W: per-channel overrange counts.

Behaviour:
- Reset (ctrl_reset=1 at a clock edge): all outputs 0; state SEARCH; history word invalid; period counter 0; hit count 0.
- in_valid=0 cycles: no state, counter or history change; out_valid=0 on the following cycle.
- Edge detection over the concatenated stream {previous valid word's sync[N_SAMP-1], sync[N_SAMP-1:0]}:
  - Edge at slot i means sync[i]=1 and the preceding sample's sync=0.
  - First valid word after reset: the preceding bit is 0.
  - Multiple edges in one word: the lowest i is used.
- Period counter:
  - Set to 0 on the word carrying an accepted edge; +1 on each subsequent valid word; saturates at all-ones.
  - An edge is expected exactly when the counter == sync_period, at slot == offset.
- FSM states:
  - SEARCH: on the first edge at slot p, offset<=p, hits<=1. If sync_period==0 or LOCK_COUNT==1 go to LOCKED, else go to VERIFY.
  - VERIFY: an expected edge at the correct slot gives hits+1; when hits reaches LOCK_COUNT go to LOCKED. Any of the following returns to SEARCH with hits=0 and offset held:
    - edge earlier than expected;
    - edge at the wrong slot;
    - counter passes sync_period with no edge.
  - LOCKED: same checks as VERIFY; a mismatch goes to SEARCH and sets lock_lost. With sync_period==0, LOCKED is held and later edges are ignored for offset.
  - A mismatch word that carries an edge is not re-used as the first SEARCH edge; acquisition restarts on the next edge.
- Realignment (realign_en=1):
  - hist = previous valid word.
  - Output sample k per channel = hist[offset+k] if offset+k<N_SAMP, else cur[offset+k-N_SAMP].
  - out_valid = registered (in_valid & hist valid); the first valid word after reset primes hist only.
  - out_sync=1 when the edge was detected in hist at slot == offset.
- Pass-through (realign_en=0): out_data = cur registered; out_valid = registered in_valid; out_sync = registered in_sync[0].
- Latency: 1 clock from an in_valid edge to an out_valid edge in both modes. Realign mode adds a one-word data delay.
- A realign_en or offset change takes effect on the next valid word.
- Overrange counters:
  - On a valid word with in_outofrange[c]=1, count[c]+1, saturating at 2^OR_CNT_W-1.
  - or_clear has priority: the result is 0 even if the same word flags overrange.
  - Counters are independent of lock state.

Test Plan:
- Reset with N_SAMP=4, sync_period=8, LOCK_COUNT=3: first 8-word sync pulse at slot 2 -> offset=2, locked=0. Edges at words 8 and 16, slot 2 -> locked=1 on the cycle after word 16; out_sync=1 with out sample 0 equal to the sync-tagged input sample.
- Locked at offset 2; next edge arrives at word 23 (one word early) -> locked=0, lock_lost=1, offset stays 2; relock after 3 correct edges; lock_lost stays 1.
- sync_period=0, edge at slot 3 -> locked=1 on the next cycle, offset=3. Ramp input 0,1,2,...: output words {3,4,5,6}, {7,8,9,10}, ...
- realign_en=0, ramp input -> out_data equals input delayed 1 clock. in_valid toggling 1,0,1 -> out_valid follows 1 cycle later.
- Channel 1 overranges on 5 valid words -> or_count[1]=5, or_count[0]=0. or_clear coincident with an overrange word -> 0. OR_CNT_W=4 with 20 overranges -> saturates at 15.
- ctrl_reset asserted mid-VERIFY -> all outputs 0 next cycle, state SEARCH; the first valid word after reset gives no out_valid.
